// File: rtl/custom_io_irq_edge.sv
// GPIO interrupt edge stage: synchronise, debounce and edge-detect each input,
// latch pending status with W1C acknowledge, drive level irq, pulse and edge count.
module custom_io_irq_edge #(
  parameter int N_IO     = 4,
  parameter int DEBOUNCE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [N_IO-1:0]  gpio_in,
  input  logic [N_IO-1:0]  rise_en,
  input  logic [N_IO-1:0]  fall_en,
  input  logic [N_IO-1:0]  irq_en,
  input  logic             global_en,
  input  logic             ack_wr,
  input  logic [N_IO-1:0]  ack_mask,
  output logic [N_IO-1:0]  status,
  output logic [N_IO-1:0]  gpio_filt,
  output logic             irq,
  output logic             irq_pulse,
  output logic [CNT_W-1:0] edge_count
);

  localparam int DB_W  = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int PC_W  = $clog2(N_IO + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_IO-1:0] sync1;
  logic [N_IO-1:0] sync2;
  logic [N_IO-1:0] filt;
  logic [N_IO-1:0] filt_d;
  logic [DB_W-1:0] db_cnt [N_IO];
  logic [1:0]      arm_cnt;
  logic            armed;

  logic [N_IO-1:0]  rise;
  logic [N_IO-1:0]  fall;
  logic [N_IO-1:0]  hit;
  logic [N_IO-1:0]  clr;
  logic [N_IO-1:0]  status_next;
  logic             irq_next;
  logic [PC_W-1:0]  hit_cnt;
  logic [SUM_W-1:0] count_sum;
  logic [CNT_W-1:0] count_next;

  assign armed     = (arm_cnt == 2'd3);
  assign gpio_filt = filt;

  // While arming, filt and filt_d both track sync2 so a level held through
  // reset looks unchanged on the first armed cycle and cannot fake an edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      filt_d  <= '0;
      arm_cnt <= '0;
      for (int i = 0; i < N_IO; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
        filt    <= sync2;
        filt_d  <= sync2;
        for (int i = 0; i < N_IO; i++) db_cnt[i] <= '0;
      end else begin
        filt_d <= filt;
        for (int i = 0; i < N_IO; i++) begin
          if (sync2[i] == filt[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DB_MAX) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end
      end
    end
  end

  // ack_wr is a single-cycle strobe with no back-pressure: ack_mask is only
  // looked at in the cycle ack_wr is high, and a same-cycle edge wins.
  always_comb begin
    rise        = filt & ~filt_d & rise_en;
    fall        = ~filt & filt_d & fall_en;
    hit         = armed ? (rise | fall) : '0;
    clr         = ack_wr ? ack_mask : '0;
    status_next = (status & ~clr) | hit;
    irq_next    = global_en & (|(status & irq_en));
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_IO; i++) hit_cnt = hit_cnt + PC_W'(hit[i]);
    count_sum = SUM_W'(edge_count) + SUM_W'(hit_cnt);
    if (count_sum > SUM_W'(CNT_MAX)) count_next = CNT_MAX;
    else                             count_next = count_sum[CNT_W-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      status     <= '0;
      irq        <= 1'b0;
      irq_pulse  <= 1'b0;
      edge_count <= '0;
    end else begin
      status     <= status_next;
      irq        <= irq_next;
      irq_pulse  <= irq_next & ~irq;
      edge_count <= count_next;
    end
  end

endmodule
